// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring/johnson sequence monitor.
// Holds the FSM state encoding and the successor function for both counter flavours.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_e;

    localparam int   RING_W    = 8;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Johnson variants invert the bit that wraps around; ring variants rotate it unchanged.
    function automatic logic [RING_W-1:0] next_expected(input logic [RING_W-1:0] p,
                                                        input logic              ring,
                                                        input logic              mode);
        logic [RING_W-1:0] n;
        if (ring) begin
            if (mode == DIR_LEFT) n = {p[RING_W-2:0], p[RING_W-1]};
            else                  n = {p[0], p[RING_W-1:1]};
        end else begin
            if (mode == DIR_LEFT) n = {p[RING_W-2:0], ~p[RING_W-1]};
            else                  n = {~p[0], p[RING_W-1:1]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ring_seq_monitor_if.sv
// Signal bundle between the observed counter and the sequence monitor.
// No handshake: count_in/ring/mode are sampled on every rising clk edge and all
// status outputs are registered copies describing the sample taken at that edge.
interface ring_seq_monitor_if #(
    parameter int ERR_W = 8
) ();
    import ring_pkg::*;

    logic [RING_W-1:0] count_in;
    logic              ring;
    logic              mode;
    logic [3:0]        phase;
    logic              phase_vld;
    logic              locked;
    logic              err;
    logic              illegal;
    logic [ERR_W-1:0]  err_cnt;
    state_e            state_dbg;

    modport master (
        output count_in, ring, mode,
        input  phase, phase_vld, locked, err, illegal, err_cnt, state_dbg
    );

    modport slave (
        input  count_in, ring, mode,
        output phase, phase_vld, locked, err, illegal, err_cnt, state_dbg
    );

endinterface

// File: rtl/ring_seq_monitor_johnson_phase_dec.sv
// Combinational johnson code decoder: phase index 0..15 plus a legality flag.
// Phase follows the left-shift johnson order starting at 0x00.
module johnson_phase_dec
    import ring_pkg::*;
(
    input  logic [RING_W-1:0] code_i,
    output logic [3:0]        phase_o,
    output logic              legal_o
);

    logic [3:0]        pop;
    logic [RING_W-1:0] inv;

    always_comb begin
        pop = '0;
        for (int i = 0; i < RING_W; i++) begin
            pop = pop + {3'd0, code_i[i]};
        end
        inv = ~code_i;
        // A run touching bit 0 is 0..01..1; a run touching bit 7 is the complement of one.
        legal_o = ((code_i & (code_i + 8'd1)) == '0) || ((inv & (inv + 8'd1)) == '0);
        if (code_i == '0)   phase_o = 4'd0;
        else if (code_i[0]) phase_o = pop;
        else                phase_o = 4'(5'd16 - {1'b0, pop});
    end

endmodule

// File: rtl/ring_seq_monitor.sv
// Checks that a ring/johnson counter steps through legal successors, acquires lock
// after LOCK_CNT clean steps, reports the counter phase and counts sequence errors.
module ring_seq_monitor
    import ring_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input logic               clk,
    input logic               rst,
    ring_seq_monitor_if.slave bus
);

    state_e            state_q, state_d;
    logic [RING_W-1:0] prev_q;
    logic              ring_q, mode_q;
    logic [3:0]        streak_q, streak_d;
    logic [2:0]        rph_q, rph_d, rph_step;
    logic [3:0]        phase_q, phase_d;
    logic              phase_vld_q, phase_vld_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              illegal_q, illegal_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic [3:0] j_phase;
    logic       j_legal;
    logic       cfg_chg, bad_code, good_step;

    johnson_phase_dec u_dec (
        .code_i  (bus.count_in),
        .phase_o (j_phase),
        .legal_o (j_legal)
    );

    always_comb begin
        cfg_chg   = (bus.ring != ring_q) || (bus.mode != mode_q);
        bad_code  = !bus.ring && !j_legal;
        good_step = (bus.count_in == next_expected(prev_q, bus.ring, bus.mode)) && !bad_code;
        rph_step  = (bus.mode == DIR_LEFT) ? rph_q + 3'd1 : rph_q - 3'd1;

        state_d     = state_q;
        streak_d    = streak_q;
        rph_d       = rph_q;
        phase_d     = '0;
        phase_vld_d = 1'b0;
        locked_d    = 1'b0;
        err_d       = 1'b0;
        illegal_d   = bad_code;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                state_d  = ACQ;
                streak_d = '0;
            end
            ACQ: begin
                if (cfg_chg || !good_step) begin
                    streak_d = '0;
                end else if (streak_q == 4'(LOCK_CNT - 1)) begin
                    state_d     = LOCK;
                    streak_d    = '0;
                    rph_d       = '0;
                    locked_d    = 1'b1;
                    phase_vld_d = 1'b1;
                    phase_d     = bus.ring ? 4'd0 : j_phase;
                end else begin
                    streak_d = streak_q + 4'd1;
                end
            end
            LOCK: begin
                // A config change is a reconfiguration, not a fault, so it never raises err.
                if (cfg_chg) begin
                    state_d  = ACQ;
                    streak_d = '0;
                end else if (!good_step) begin
                    state_d  = ACQ;
                    streak_d = '0;
                    err_d    = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
                end else begin
                    rph_d       = rph_step;
                    locked_d    = 1'b1;
                    phase_vld_d = 1'b1;
                    phase_d     = bus.ring ? {1'b0, rph_step} : j_phase;
                end
            end
            default: begin
                state_d  = IDLE;
                streak_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            ring_q      <= 1'b0;
            mode_q      <= 1'b0;
            streak_q    <= '0;
            rph_q       <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            illegal_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= bus.count_in;
            ring_q      <= bus.ring;
            mode_q      <= bus.mode;
            streak_q    <= streak_d;
            rph_q       <= rph_d;
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            illegal_q   <= illegal_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.phase     = phase_q;
    assign bus.phase_vld = phase_vld_q;
    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.illegal   = illegal_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Bench for ring_seq_monitor: reference model feeds an expected queue per driven
// sample; outputs are compared just after the edge that registered them.
module tb_ring_seq_monitor;
  import ring_pkg::*;

  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int EXP_W    = 18;

  logic clk;
  logic rst;

  ring_seq_monitor_if #(.ERR_W(ERR_W)) bus ();

  ring_seq_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  int n_checks;
  int n_fail;
  logic [EXP_W-1:0] exp_q[$];
  logic [7:0] jtab[16];

  // reference model state
  int         m_st;
  int         m_streak;
  int         m_rph;
  int         m_cnt;
  logic [7:0] m_prev;
  logic       m_ring;
  logic       m_mode;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_next(input logic [7:0] p, input logic r, input logic m);
    logic [7:0] lsh;
    logic [7:0] rsh;
    logic [7:0] res;
    lsh = p << 1;
    rsh = p >> 1;
    if (r) res = m ? (lsh | (p >> 7)) : (rsh | {p[0], 7'd0});
    else   res = m ? (lsh | {7'd0, ~p[7]}) : (rsh | {~p[0], 7'd0});
    return res;
  endfunction

  function automatic bit jlookup(input logic [7:0] c, output int ph);
    ph = 0;
    for (int i = 0; i < 16; i++) begin
      if (jtab[i] == c) begin
        ph = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_streak = 0; m_rph = 0; m_cnt = 0;
    m_prev = 8'h00; m_ring = 1'b0; m_mode = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] c, input logic r, input logic m);
    bit cfg, legal, bad, good;
    int ph, e_phase;
    bit e_vld, e_lock, e_err;
    cfg   = (r != m_ring) || (m != m_mode);
    legal = jlookup(c, ph);
    bad   = !r && !legal;
    good  = (c == exp_next(m_prev, r, m)) && !bad;
    e_phase = 0; e_vld = 0; e_lock = 0; e_err = 0;
    case (m_st)
      0: begin m_st = 1; m_streak = 0; end
      1: begin
        if (cfg || !good) m_streak = 0;
        else begin
          m_streak++;
          if (m_streak == LOCK_CNT) begin
            m_st = 2; m_streak = 0; m_rph = 0;
            e_lock = 1; e_vld = 1; e_phase = r ? 0 : ph;
          end
        end
      end
      default: begin
        if (cfg) begin
          m_st = 1; m_streak = 0;
        end else if (!good) begin
          e_err = 1;
          if (m_cnt < 255) m_cnt++;
          m_st = 1; m_streak = 0;
        end else begin
          m_rph = m ? (m_rph + 1) % 8 : (m_rph + 7) % 8;
          e_lock = 1; e_vld = 1; e_phase = r ? m_rph : ph;
        end
      end
    endcase
    m_prev = c; m_ring = r; m_mode = m;
    exp_q.push_back({2'(m_st), 4'(e_phase), e_vld, e_lock, e_err, bad, 8'(m_cnt)});
  endtask

  task automatic compare_out();
    logic [EXP_W-1:0] e;
    check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("state",     32'(bus.state_dbg), 32'(e[17:16]));
      check_eq("phase",     32'(bus.phase),     32'(e[15:12]));
      check_eq("phase_vld", 32'(bus.phase_vld), 32'(e[11]));
      check_eq("locked",    32'(bus.locked),    32'(e[10]));
      check_eq("err",       32'(bus.err),       32'(e[9]));
      check_eq("illegal",   32'(bus.illegal),   32'(e[8]));
      check_eq("err_cnt",   32'(bus.err_cnt),   32'(e[7:0]));
    end
  endtask

  // driver tasks
  task automatic drive_step(input logic [7:0] c, input logic r, input logic m, input bit rst_glitch);
    @(negedge clk);
    rst = 1'b1;
    bus.count_in = c; bus.ring = r; bus.mode = m;
    model_step(c, r, m);
    if (rst_glitch) begin
      #2 rst = 1'b0;
      #1 rst = 1'b1;
    end
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b0;
    bus.count_in = 8'($urandom_range(0, 255));
    model_reset();
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  logic [7:0] seq[$];
  logic [7:0] code;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    code = 8'h00;
    for (int i = 0; i < 16; i++) begin
      jtab[i] = code;
      code = {code[6:0], ~code[7]};
    end
    rst = 1'b0;
    bus.count_in = 8'h00; bus.ring = 1'b0; bus.mode = 1'b0;
    model_reset();

    reset_cycle();
    reset_cycle();
    check_eq("rst_locked", 32'(bus.locked), 32'd0);
    check_eq("rst_cnt", 32'(bus.err_cnt), 32'd0);

    // ring left acquisition and phase count-up
    seq = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30};
    foreach (seq[i]) begin
      drive_step(seq[i], 1'b1, 1'b1, 1'b0);
      if (i == 3) check_eq("ring_prelock", 32'(bus.locked), 32'd0);
    end
    check_eq("ring_lock", 32'(bus.locked), 32'd1);
    check_eq("ring_ph0", 32'(bus.phase), 32'd0);
    drive_step(8'h60, 1'b1, 1'b1, 1'b0);
    check_eq("ring_ph1", 32'(bus.phase), 32'd1);
    drive_step(8'hC0, 1'b1, 1'b1, 1'b0);

    // direction flip: drops lock without error, relocks and counts down
    drive_step(8'h60, 1'b1, 1'b0, 1'b0);
    check_eq("flip_unlock", 32'(bus.locked), 32'd0);
    check_eq("flip_noerr", 32'(bus.err), 32'd0);
    check_eq("flip_cnt", 32'(bus.err_cnt), 32'd0);
    seq = '{8'h30, 8'h18, 8'h0C, 8'h06};
    foreach (seq[i]) drive_step(seq[i], 1'b1, 1'b0, 1'b0);
    check_eq("flip_relock", 32'(bus.locked), 32'd1);
    check_eq("flip_ph0", 32'(bus.phase), 32'd0);
    drive_step(8'h03, 1'b1, 1'b0, 1'b0);
    check_eq("flip_ph7", 32'(bus.phase), 32'd7);
    drive_step(8'h81, 1'b1, 1'b0, 1'b0);
    check_eq("flip_ph6", 32'(bus.phase), 32'd6);

    // johnson left phases
    seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    foreach (seq[i]) drive_step(seq[i], 1'b0, 1'b1, 1'b0);
    check_eq("j_lock", 32'(bus.locked), 32'd1);
    check_eq("j_ph4", 32'(bus.phase), 32'd4);
    drive_step(8'h1F, 1'b0, 1'b1, 1'b0);
    check_eq("j_ph5", 32'(bus.phase), 32'd5);
    drive_step(8'h3F, 1'b0, 1'b1, 1'b0);
    drive_step(8'h7F, 1'b0, 1'b1, 1'b0);
    drive_step(8'hFF, 1'b0, 1'b1, 1'b0);
    check_eq("j_ph8", 32'(bus.phase), 32'd8);
    drive_step(8'hFE, 1'b0, 1'b1, 1'b0);
    check_eq("j_ph9", 32'(bus.phase), 32'd9);

    // glitch while locked in johnson mode
    reset_cycle();
    seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    foreach (seq[i]) drive_step(seq[i], 1'b0, 1'b1, 1'b0);
    drive_step(8'h05, 1'b0, 1'b1, 1'b0);
    check_eq("g_err", 32'(bus.err), 32'd1);
    check_eq("g_illegal", 32'(bus.illegal), 32'd1);
    check_eq("g_cnt", 32'(bus.err_cnt), 32'd1);
    check_eq("g_unlock", 32'(bus.locked), 32'd0);
    seq = '{8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC};
    foreach (seq[i]) begin
      drive_step(seq[i], 1'b0, 1'b1, 1'b0);
      if (i == 0) check_eq("g_pulse_end", 32'(bus.err), 32'd0);
      if (i == 3) check_eq("g_prelock", 32'(bus.locked), 32'd0);
    end
    check_eq("g_relock", 32'(bus.locked), 32'd1);
    check_eq("g_ph10", 32'(bus.phase), 32'd10);

    // two more errors, relock, then reset while locked with err_cnt=3
    seq = '{8'h05, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h05, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    foreach (seq[i]) drive_step(seq[i], 1'b0, 1'b1, 1'b0);
    check_eq("r_cnt3", 32'(bus.err_cnt), 32'd3);
    check_eq("r_locked", 32'(bus.locked), 32'd1);
    drive_step(8'h1F, 1'b0, 1'b1, 1'b1);
    check_eq("async_ignored", 32'(bus.locked), 32'd1);
    check_eq("async_ph5", 32'(bus.phase), 32'd5);
    reset_cycle();
    check_eq("r_state", 32'(bus.state_dbg), 32'(IDLE));
    check_eq("r_cnt0", 32'(bus.err_cnt), 32'd0);
    check_eq("r_unlock", 32'(bus.locked), 32'd0);

    // saturation: lock, glitch, repeat
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    foreach (seq[i]) drive_step(seq[i], 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      foreach (seq[i]) drive_step(seq[i], 1'b1, 1'b1, 1'b0);
      if (k == 254) check_eq("sat_254", 32'(bus.err_cnt), 32'd255);
    end
    check_eq("sat_hold", 32'(bus.err_cnt), 32'd255);
    drive_step(8'h01, 1'b1, 1'b1, 1'b0);
    check_eq("sat_err", 32'(bus.err), 32'd1);
    check_eq("sat_final", 32'(bus.err_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_seq_monitor.md
Name: ring_seq_monitor

Overview:
- Downstream checker for the 8-bit ring/johnson counter output; samples `count` every clock.
- Verifies each step is the legal successor for the current `ring`/`mode` configuration.
- Decodes the counter phase, acquires lock after a run of clean steps, flags and counts sequence errors.
- Feeds status/phase to the control and debug logic that consumes the counter.

Parameters:
- LOCK_CNT, 4, consecutive valid transitions required to assert `locked` (range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- count_in  input  8  counter output under observation.
- ring  input  1  1 = ring mode (rotate), 0 = johnson mode (twisted shift).
- mode  input  1  shift direction: 1 = left (toward bit 7), 0 = right.
- phase  output  4  decoded phase index (0..15 johnson, 0..7 ring).
- phase_vld  output  1  phase valid (state LOCK).
- locked  output  1  sequence locked.
- err  output  1  one-cycle pulse on a sequence error while locked.
- illegal  output  1  current sample is not a legal johnson code (johnson mode only, registered).
- err_cnt  output  ERR_W  saturating count of `err` pulses.

Behaviour:
- Reset: when rst==0 at posedge, state=IDLE and prev=0. All outputs go to 0, including `err_cnt`. Reset has priority over everything, including mid-lock.
- All outputs are registered. Responses reflect the sample taken at that edge.
- Expected successor, with p = prev:
  - ring left: {p[6:0],p[7]}
  - ring right: {p[0],p[7:1]}
  - johnson left: {p[6:0],~p[7]}
  - johnson right: {~p[0],p[7:1]}
- Johnson legality: the code is 0x00, or a contiguous run of ones touching bit 0, or a contiguous run touching bit 7 (16 codes).
- Johnson phase: 0x00 gives 0. If c[0]==1, phase = popcount(c), so 0xFF gives 8. Otherwise phase = 16 - popcount(c).
- Ring phase: rotation counter. Set to 0 on ACQ→LOCK entry. Increments mod 8 per valid step when mode=1, decrements when mode=0.
- prev <= count_in every non-reset edge. ring/mode are also registered each edge to detect changes.
- State machine:
  - IDLE: capture the first sample, go to ACQ, streak=0.
  - ACQ: valid step gives streak+1. Invalid step or illegal code gives streak=0, with no err pulse. When streak reaches LOCK_CNT: go to LOCK, locked=1, phase_vld=1.
  - LOCK: valid step updates phase. Invalid step or illegal code gives err=1 for one cycle, err_cnt+1 (holding at 2^ERR_W-1), locked=0, phase_vld=0, go to ACQ, streak=0.
- Config change (ring or mode differs from the previous edge) in any state: go to ACQ, streak=0, locked=0. No err, no err_cnt increment. That edge's step is not checked.
- Simultaneous config change and invalid step: config change wins, no error.
- `illegal` is forced to 0 in ring mode. Any nonzero or zero ring pattern is accepted.
- A constant all-zero input in ring mode is a valid rotation. No special case.

Decomposition:
- Shared package ring_pkg holds:
  - state enum IDLE/ACQ/LOCK
  - constants RING_W=8, DIR_LEFT=1, DIR_RIGHT=0
  - function next_expected(p, ring, mode)
- Sub-module johnson_phase_dec (combinational): 8-bit code in, 4-bit phase out, legal flag out.

Test Plan:
- Ring left, stream 0x03,0x06,0x0C,0x18,0x30 from the first post-reset edge → locked=1 after the 5th edge (LOCK_CNT=4), phase=0 there, then 1 on 0x60.
- Johnson left, stream 0x00,0x01,0x03,0x07,0x0F,0x1F → locked after the 5th edge. Phases shown at 0x0F, 0x1F are 4, 5. Continue to 0xFF → phase 8, then 0xFE → 9.
- Locked in johnson left, then inject 0x05 in place of the expected 0x3F → err pulse exactly 1 cycle, illegal=1, err_cnt 0→1, locked=0. Resume a legal sequence → relock after 4 valid steps.
- Locked in ring left, flip mode to 0 with the stream reversed accordingly → locked drops, err stays 0, err_cnt unchanged. Relock after 4 valid right rotations, then phase decrements 0→7→6.
- Force 300 errors (ERR_W=8) by alternating lock/glitch → err_cnt saturates at 255.
- Assert rst=0 for one edge while locked with err_cnt=3 → next cycle all outputs 0, state IDLE. An asynchronous rst pulse between edges has no effect.
